rr_lock_arbiter: RTL and testbench
==================================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 8: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter ID_W, default 3: width of each id field.
REQ-003 SHALL have parameter OFF_W, default 3: width of each offset field.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port io_in_valid, input, N_IN bits: per-channel request.
REQ-007 SHALL have port io_in_ready, output, N_IN bits: per-channel accept.
REQ-008 SHALL have port io_in_bits_id, input, N_IN*ID_W bits: channel i at [i*ID_W +: ID_W].
REQ-009 SHALL have port io_in_bits_offset, input, N_IN*OFF_W bits: channel i at [i*OFF_W +: OFF_W].
REQ-010 SHALL have port io_in_bits_last, input, N_IN bits: final beat of a burst.
REQ-011 SHALL have port io_out_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have port io_out_valid, output, 1 bit: registered output valid.
REQ-013 SHALL have ports io_out_bits_id (ID_W), io_out_bits_offset (OFF_W) and io_out_bits_last (1), all outputs: registered payload.
REQ-014 SHALL have port io_out_chosen, output, $clog2(N_IN) bits: index of the source channel of the held beat.

Function
REQ-015 SHALL hold one output slot; slot_free = ~io_out_valid | io_out_ready.
REQ-016 SHALL compute the grant combinationally: the first valid channel searched from ptr+1 upward, wrapping modulo N_IN.
REQ-017 SHALL drive io_in_ready[i] = grant[i] & slot_free; at most one bit set; io_in_ready SHALL NOT depend on io_in_valid of the same channel other than through the grant.
REQ-018 SHALL load the granted payload, last and index into the slot on the accept (valid & ready), giving 1-cycle latency from accept to io_out_valid.
REQ-019 SHALL clear io_out_valid when io_out_ready is high and no accept occurs; a simultaneous drain and accept SHALL keep io_out_valid high with the new beat (full throughput).
REQ-020 SHALL hold the slot stable while io_out_valid & ~io_out_ready.
REQ-021 SHALL update ptr to the accepted index on every accept.
REQ-022 SHALL, when no input is valid, keep ptr unchanged and drive all io_in_ready low.
REQ-023 SHALL treat N_IN that is not a power of two correctly: the wrap excludes indices >= N_IN.

Reset
REQ-024 SHALL, while reset is low, force io_out_valid=0, io_out_bits_id=0, io_out_bits_offset=0, io_out_bits_last=0, io_out_chosen=0, ptr=N_IN-1 (so channel 0 has first priority), lock=0 and lock_idx=0.
REQ-025 SHALL abandon a slot or lock in flight when reset asserts mid-operation; state SHALL resume from the reset values on the first edge after deassertion.

Configuration
REQ-026 With RR_ARB_LOCK_EN defined: an accepted beat with last=0 SHALL set lock and set lock_idx to the accepted index; while locked, the grant SHALL be forced to lock_idx (others not ready, even if lock_idx is idle); an accepted beat with last=1 from lock_idx SHALL clear lock.
REQ-027 Without RR_ARB_LOCK_EN: there SHALL be no lock state, every beat SHALL be re-arbitrated, and last SHALL be passed through only.

Structure
REQ-028 SHALL place the payload struct typedef (id, offset, last) and the N_IN range-check constants in package rr_arb_pkg.
REQ-029 SHALL use one combinational sub-module, rr_arb_pick, mapping (valid vector, ptr) to a one-hot grant and an index; the slot and lock logic live in rr_lock_arbiter.

Verification
REQ-030 The bench SHALL check: after reset, all 8 valid and io_out_ready=1 -> grants 0,1,...,7,0 on consecutive cycles, io_out_valid continuously 1 from cycle 1.
REQ-031 The bench SHALL check: ch2 and ch5 valid, io_out_ready held 0 for 3 cycles -> one beat (ch2) held stable, io_in_ready all 0 until release, then ch5.
REQ-032 The bench SHALL check (LOCK_EN): ch3 sends 3 beats, last on beat 3, while ch4 is valid -> ch4 not granted until the cycle after ch3's last beat is accepted.
REQ-033 The bench SHALL check (no LOCK_EN): the same stimulus -> ch3 and ch4 alternate.
REQ-034 The bench SHALL check: reset asserted while locked with io_out_valid=1 -> io_out_valid=0 immediately (asynchronously) and channel 0 granted first afterward.
REQ-035 The bench SHALL check: N_IN=5 with only ch4 and ch0 valid -> order 0,4,0,4 with no out-of-range index.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared payload type and channel-count limits for the round-robin lock arbiter
package rr_arb_pkg;

    // Legal channel-count window for rr_lock_arbiter.
    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 16;

    // Payload field widths carried by the output slot.
    localparam int PAYLOAD_ID_W  = 3;
    localparam int PAYLOAD_OFF_W = 3;

    typedef struct packed {
        logic [PAYLOAD_ID_W-1:0]  id;
        logic [PAYLOAD_OFF_W-1:0] offset;
        logic                     last;
    } rr_payload_t;

    function automatic bit n_in_legal(input int n);
        return (n >= N_IN_MIN) && (n <= N_IN_MAX);
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin pick: first valid channel after ptr, wrapping modulo N_IN
module rr_arb_pick #(
    parameter int N_IN = 8
) (
    input  logic [N_IN-1:0]         valid,
    input  logic [$clog2(N_IN)-1:0] ptr,
    output logic [N_IN-1:0]         grant,
    output logic [$clog2(N_IN)-1:0] idx
);

    localparam int IDX_W = $clog2(N_IN);

    logic [IDX_W:0] cand;
    logic           found;

    // Walk ptr+1 .. ptr+N_IN; one subtraction keeps the candidate below N_IN
    // so non-power-of-two channel counts never produce an out-of-range index.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_IN)) begin
                cand = cand - (IDX_W+1)'(N_IN);
            end
            if (!found && valid[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin N-to-1 arbiter with one registered output slot; burst lock when RR_ARB_LOCK_EN is defined
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int ID_W  = 3,
    parameter int OFF_W = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_IN-1:0]          io_in_valid,
    output logic [N_IN-1:0]          io_in_ready,
    input  logic [N_IN*ID_W-1:0]     io_in_bits_id,
    input  logic [N_IN*OFF_W-1:0]    io_in_bits_offset,
    input  logic [N_IN-1:0]          io_in_bits_last,
    input  logic                     io_out_ready,
    output logic                     io_out_valid,
    output logic [ID_W-1:0]          io_out_bits_id,
    output logic [OFF_W-1:0]         io_out_bits_offset,
    output logic                     io_out_bits_last,
    output logic [$clog2(N_IN)-1:0]  io_out_chosen
);

    localparam int IDX_W = $clog2(N_IN);

    // Elaboration-time guards on the configuration.
    if (!n_in_legal(N_IN)) begin : g_bad_n_in
        $error("rr_lock_arbiter: N_IN out of range");
    end
    if ((ID_W != PAYLOAD_ID_W) || (OFF_W != PAYLOAD_OFF_W)) begin : g_bad_width
        $error("rr_lock_arbiter: ID_W/OFF_W must match rr_arb_pkg payload widths");
    end

    rr_payload_t      slot_q, slot_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] chosen_q, chosen_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             slot_free;
    logic [N_IN-1:0]  pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [N_IN-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             accept;
    rr_payload_t      in_beat;

    rr_arb_pick #(
        .N_IN (N_IN)
    ) u_pick (
        .valid (io_in_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

`ifdef RR_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [N_IN-1:0]  lock_grant;

    // While locked the grant is pinned to the burst owner, even when it is idle.
    always_comb begin
        lock_grant             = '0;
        lock_grant[lock_idx_q] = 1'b1;
        grant                  = lock_q ? lock_grant : pick_grant;
        grant_idx              = lock_q ? lock_idx_q : pick_idx;
    end

    // A non-final beat opens (or keeps) the lock; the owner's final beat releases it.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (!in_beat.last) begin
                lock_d     = 1'b1;
                lock_idx_d = grant_idx;
            end else if (grant_idx == lock_idx_q) begin
                lock_d     = 1'b0;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    // Every beat is re-arbitrated; last is carried through untouched.
    always_comb begin
        grant     = pick_grant;
        grant_idx = pick_idx;
    end
`endif

    // Handshake: the slot can take a beat when empty or draining this cycle.
    always_comb begin
        slot_free   = ~out_valid_q | io_out_ready;
        io_in_ready = grant & {N_IN{slot_free}};
        accept      = |(io_in_valid & io_in_ready);
    end

    // Select the granted channel's payload fields.
    always_comb begin
        in_beat        = '0;
        in_beat.id     = io_in_bits_id[int'(grant_idx)*ID_W +: ID_W];
        in_beat.offset = io_in_bits_offset[int'(grant_idx)*OFF_W +: OFF_W];
        in_beat.last   = io_in_bits_last[grant_idx];
    end

    // Slot and pointer update: load on accept, empty on a drain without refill, hold otherwise.
    always_comb begin
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        chosen_d    = chosen_q;
        ptr_d       = ptr_q;
        if (accept) begin
            slot_d      = in_beat;
            out_valid_d = 1'b1;
            chosen_d    = grant_idx;
            ptr_d       = grant_idx;
        end else if (io_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Slot state register; ptr resets to the last channel so channel 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            chosen_q    <= '0;
            ptr_q       <= IDX_W'(N_IN-1);
        end else begin
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            chosen_q    <= chosen_d;
            ptr_q       <= ptr_d;
        end
    end

    assign io_out_valid       = out_valid_q;
    assign io_out_bits_id     = slot_q.id;
    assign io_out_bits_offset = slot_q.offset;
    assign io_out_bits_last   = slot_q.last;
    assign io_out_chosen      = chosen_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed and randomized checks of rr_lock_arbiter (N_IN=8 and N_IN=5) against a behavioural model
module tb_rr_lock_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0]  v8, last8, irdy8;
    logic [23:0] id8, off8;
    logic        ordy8, ov8, olast8;
    logic [2:0]  oid8, ooff8, ch8;

    logic [4:0]  v5, last5, irdy5;
    logic [14:0] id5, off5;
    logic        ordy5, ov5, olast5;
    logic [2:0]  oid5, ooff5, ch5;

    int n_pass = 0;
    int n_total = 0;

    // Reference state, index 0 = 8-channel instance, index 1 = 5-channel instance.
    int m_ptr[2];
    bit m_lock[2];
    int m_lidx[2];
    bit m_ov[2];
    int m_id[2];
    int m_off[2];
    int m_last[2];
    int m_ch[2];

    rr_lock_arbiter #(.N_IN(8), .ID_W(3), .OFF_W(3)) dut8 (
        .clock(clk), .reset(rst_n),
        .io_in_valid(v8), .io_in_ready(irdy8),
        .io_in_bits_id(id8), .io_in_bits_offset(off8), .io_in_bits_last(last8),
        .io_out_ready(ordy8), .io_out_valid(ov8),
        .io_out_bits_id(oid8), .io_out_bits_offset(ooff8), .io_out_bits_last(olast8),
        .io_out_chosen(ch8)
    );

    rr_lock_arbiter #(.N_IN(5), .ID_W(3), .OFF_W(3)) dut5 (
        .clock(clk), .reset(rst_n),
        .io_in_valid(v5), .io_in_ready(irdy5),
        .io_in_bits_id(id5), .io_in_bits_offset(off5), .io_in_bits_last(last5),
        .io_out_ready(ordy5), .io_out_valid(ov5),
        .io_out_bits_id(oid5), .io_out_bits_offset(ooff5), .io_out_bits_last(olast5),
        .io_out_chosen(ch5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        for (int w = 0; w < 2; w++) begin
            m_ptr[w]  = (w == 0) ? 7 : 4;
            m_lock[w] = 1'b0;
            m_lidx[w] = 0;
            m_ov[w]   = 1'b0;
            m_id[w]   = 0;
            m_off[w]  = 0;
            m_last[w] = 0;
            m_ch[w]   = 0;
        end
    endtask

    // Round-robin rule: owner of an open burst if locked, else first valid after ptr.
    function automatic int ref_grant(input int w, input logic [15:0] v, input int n);
`ifdef RR_ARB_LOCK_EN
        if (m_lock[w]) return m_lidx[w];
`endif
        for (int k = 1; k <= n; k++) begin
            if (v[(m_ptr[w] + k) % n]) return (m_ptr[w] + k) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int w);
        int n, g;
        bit free;
        logic [15:0] v, rdy, lastv;
        logic [47:0] idv, offv;
        logic o_ready, ov_obs, last_obs;
        logic [2:0] id_obs, off_obs, ch_obs;
        logic [31:0] exp_rdy;
        if (w == 0) begin
            n = 8; v = {8'b0, v8}; rdy = {8'b0, irdy8}; lastv = {8'b0, last8};
            idv = {24'b0, id8}; offv = {24'b0, off8}; o_ready = ordy8;
            ov_obs = ov8; id_obs = oid8; off_obs = ooff8; last_obs = olast8; ch_obs = ch8;
        end else begin
            n = 5; v = {11'b0, v5}; rdy = {11'b0, irdy5}; lastv = {11'b0, last5};
            idv = {33'b0, id5}; offv = {33'b0, off5}; o_ready = ordy5;
            ov_obs = ov5; id_obs = oid5; off_obs = ooff5; last_obs = olast5; ch_obs = ch5;
        end
        chk($sformatf("n%0d_out_valid", n), ov_obs, m_ov[w]);
        chk($sformatf("n%0d_out_id", n), id_obs, m_id[w]);
        chk($sformatf("n%0d_out_offset", n), off_obs, m_off[w]);
        chk($sformatf("n%0d_out_last", n), last_obs, m_last[w]);
        chk($sformatf("n%0d_out_chosen", n), ch_obs, m_ch[w]);
        g = ref_grant(w, v, n);
        free = !m_ov[w] || o_ready;
        exp_rdy = (g >= 0 && free) ? (32'd1 << g) : 32'd0;
        chk($sformatf("n%0d_in_ready", n), {16'b0, rdy}, exp_rdy);
        if (g >= 0 && free && v[g]) begin
            m_ov[w]   = 1'b1;
            m_id[w]   = int'(idv[g*3 +: 3]);
            m_off[w]  = int'(offv[g*3 +: 3]);
            m_last[w] = int'(lastv[g]);
            m_ch[w]   = g;
            m_ptr[w]  = g;
`ifdef RR_ARB_LOCK_EN
            if (!lastv[g]) begin
                m_lock[w] = 1'b1;
                m_lidx[w] = g;
            end else begin
                m_lock[w] = 1'b0;
            end
`endif
        end else if (o_ready) begin
            m_ov[w] = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", ov8, 0);
        chk("reset_out_id", oid8, 0);
        chk("reset_out_offset", ooff8, 0);
        chk("reset_out_last", olast8, 0);
        chk("reset_out_chosen", ch8, 0);
        chk("reset_out_valid_n5", ov5, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int beats;
        int exp_seq[5];
        rst_n = 1'b0;
        v8 = '0; last8 = '0; id8 = '0; off8 = '0; ordy8 = 1'b0;
        v5 = '0; last5 = '0; id5 = '0; off5 = '0; ordy5 = 1'b0;
        do_reset();

        // All eight channels valid: grants sweep 0..7 and wrap; N_IN=5 with ch0/ch4 alternates.
        v8 = 8'hFF; last8 = 8'hFF; ordy8 = 1'b1;
        v5 = 5'b10001; last5 = 5'h1F; ordy5 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            id8 = 24'($urandom); off8 = 24'($urandom);
            id5 = 15'($urandom); off5 = 15'($urandom);
            sample();
            chk("sweep_ready", irdy8, 32'd1 << (c % 8));
            chk("n5_ready", irdy5, (c % 2 == 1) ? 32'd16 : 32'd1);
            chk("n5_chosen_range", (ch5 < 3'd5), 1);
            if (c >= 1) begin
                chk("sweep_valid", ov8, 1);
                chk("sweep_chosen", ch8, (c - 1) % 8);
                chk("n5_chosen", ch5, ((c - 1) % 2 == 1) ? 4 : 0);
            end
            advance();
        end

        // Nothing valid: no ready.
        v8 = '0; v5 = '0;
        sample();
        chk("idle_ready", irdy8, 0);
        advance();

        // Backpressure: ch2 beat held while downstream stalls, then ch5.
        do_reset();
        v8 = 8'b0010_0100; last8 = 8'hFF; ordy8 = 1'b0;
        id8 = '0; id8[2*3 +: 3] = 3'd6; id8[5*3 +: 3] = 3'd1;
        sample();
        chk("stall_first_ready", irdy8, 32'h4);
        advance();
        id8[2*3 +: 3] = 3'd2;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stall_ready", irdy8, 0);
            chk("stall_valid", ov8, 1);
            chk("stall_chosen", ch8, 2);
            chk("stall_id", oid8, 6);
            advance();
        end
        ordy8 = 1'b1;
        sample();
        chk("release_ready", irdy8, 32'h20);
        chk("release_chosen", ch8, 2);
        advance();
        sample();
        chk("after_release_chosen", ch8, 5);
        chk("after_release_id", oid8, 1);
        advance();

        // Three-beat burst on ch3 competing with ch4.
        do_reset();
`ifdef RR_ARB_LOCK_EN
        exp_seq = '{8, 8, 8, 16, 16};
`else
        exp_seq = '{8, 16, 8, 16, 8};
`endif
        beats = 0; ordy8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            v8 = ((beats < 3) ? 8'h08 : 8'h00) | 8'h10;
            last8 = 8'h10 | ((beats == 2) ? 8'h08 : 8'h00);
            sample();
            chk("burst_ready", irdy8, exp_seq[c]);
            if (irdy8[3] && v8[3]) beats++;
            advance();
        end

        // Asynchronous reset while a beat is held (and a burst is open when locking).
        do_reset();
        v8 = 8'h08; last8 = 8'h00; ordy8 = 1'b0;
        sample();
        advance();
        chk("pre_reset_valid", ov8, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", ov8, 0);
        reset_model();
        v8 = 8'hFF; last8 = 8'hFF; ordy8 = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        chk("post_reset_grant", irdy8, 1);
        advance();

        // Randomized traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            v8 = 8'($urandom); last8 = 8'($urandom);
            id8 = 24'($urandom); off8 = 24'($urandom);
            ordy8 = ($urandom_range(0, 9) < 7);
            v5 = 5'($urandom); last5 = 5'($urandom);
            id5 = 15'($urandom); off5 = 15'($urandom);
            ordy5 = ($urandom_range(0, 9) < 7);
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
